// File: rtl/ahb_burst_slave_if.sv
// AHB slave bus plus downstream request/response channels for ahb_burst_slave.
// The slave modport is the DUT view; the master modport is the driving side.
interface ahb_burst_slave_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              Hsel;
    logic              Hwrite;
    logic              Hready;
    logic [1:0]        Htrans;
    logic [2:0]        Hsize;
    logic [2:0]        Hburst;
    logic [ADDR_W-1:0] Haddr;
    logic [DATA_W-1:0] Hwdata;
    logic              Hreadyout;
    logic              Hresp;
    logic [DATA_W-1:0] Hrdata;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_last;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport slave (
        input  Hsel, Hwrite, Hready, Htrans, Hsize, Hburst, Haddr, Hwdata,
        output Hreadyout, Hresp, Hrdata,
        output req_valid, req_write, req_addr, req_wdata, req_last,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output Hsel, Hwrite, Hready, Htrans, Hsize, Hburst, Haddr, Hwdata,
        input  Hreadyout, Hresp, Hrdata,
        input  req_valid, req_write, req_addr, req_wdata, req_last,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ahb_burst_slave.sv
// AHB burst slave: turns AHB transfers into entries of an in-order request FIFO.
// Writes are posted; reads wait for one downstream response. Illegal transfers
// (misaligned or oversize) get a two-cycle ERROR response and are never queued.
// Optional macro AHB_BURST_SLAVE_ADDR_CHECK_EN: check each SEQ address against
// the INCR/WRAP address sequence and treat a mismatch as illegal.
module ahb_burst_slave #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input logic              Hclk,
    input logic              Hresetn,
    ahb_burst_slave_if.slave bus
);
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam logic [2:0]  MAX_SIZE = (DATA_W == 64) ? 3'd3 : 3'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD, S_RWAIT, S_RDONE, S_ERR1, S_ERR2
    } state_e;

    state_e r_state;
    state_e w_state_next;

    // Address-phase capture for the current data phase
    logic [ADDR_W-1:0] r_addr;
    logic              r_last;
    logic [3:0]        r_beat;
    logic [DATA_W-1:0] r_hrdata;

    // Request FIFO
    logic              r_fifo_write [DEPTH];
    logic [ADDR_W-1:0] r_fifo_addr  [DEPTH];
    logic [DATA_W-1:0] r_fifo_wdata [DEPTH];
    logic              r_fifo_last  [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_accept;
    logic              w_is_seq;
    logic [4:0]        w_burst_len;
    logic [3:0]        w_beat_idx;
    logic              w_last;
    logic [ADDR_W-1:0] w_align_mask;
    logic              w_addr_bad;
    logic              w_illegal;
    state_e            w_phase_state;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_stall;
    logic              w_push;
    logic [DATA_W-1:0] w_push_wdata;
    logic              w_hreadyout;
    logic              w_hresp;

    assign w_accept = bus.Hsel && bus.Hready && bus.Htrans[1];
    assign w_is_seq = (bus.Htrans == 2'b11);

    // Burst length and beat position of the transfer in its address phase
    always_comb begin
        w_burst_len = 5'd1;
        case (bus.Hburst)
            3'd2, 3'd3: w_burst_len = 5'd4;
            3'd4, 3'd5: w_burst_len = 5'd8;
            3'd6, 3'd7: w_burst_len = 5'd16;
            default:    w_burst_len = 5'd1;
        endcase
        w_beat_idx = w_is_seq ? r_beat + 4'd1 : 4'd0;
        w_last     = 1'b0;
        case (bus.Hburst)
            3'd0:    w_last = 1'b1;
            3'd1:    w_last = 1'b0;
            default: w_last = ({1'b0, w_beat_idx} == (w_burst_len - 5'd1));
        endcase
    end

    assign w_align_mask = ADDR_W'((32'd1 << bus.Hsize) - 32'd1);

`ifdef AHB_BURST_SLAVE_ADDR_CHECK_EN
    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_sum;
    logic [ADDR_W-1:0] w_wrap_mask;
    logic [ADDR_W-1:0] w_exp_addr;
    logic              w_is_wrap;

    // Expected SEQ address: previous beat plus transfer size, wrapped for WRAPx
    always_comb begin
        w_incr      = ADDR_W'(32'd1 << bus.Hsize);
        w_sum       = r_addr + w_incr;
        w_wrap_mask = ADDR_W'(({27'd0, w_burst_len} << bus.Hsize) - 32'd1);
        w_is_wrap   = !bus.Hburst[0] && (bus.Hburst != 3'd0);
        w_exp_addr  = w_is_wrap ? ((r_addr & ~w_wrap_mask) | (w_sum & w_wrap_mask)) : w_sum;
        w_addr_bad  = w_is_seq && (bus.Haddr != w_exp_addr);
    end
`else
    assign w_addr_bad = 1'b0;
`endif

    assign w_illegal = (|(bus.Haddr & w_align_mask)) || (bus.Hsize > MAX_SIZE) || w_addr_bad;

    // Where a newly accepted address phase (or its absence) leads
    always_comb begin
        w_phase_state = S_IDLE;
        if (w_accept) begin
            if (w_illegal)       w_phase_state = S_ERR1;
            else if (bus.Hwrite) w_phase_state = S_WR;
            else                 w_phase_state = S_RD;
        end
    end

    // A pop in the same cycle frees the slot, so full only stalls without a pop
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_pop        = !w_empty && bus.req_ready;
    assign w_stall      = w_full && !w_pop;
    assign w_push       = ((r_state == S_WR) || (r_state == S_RD)) && !w_stall;
    assign w_push_wdata = (r_state == S_WR) ? bus.Hwdata : '0;

    // FSM state register
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_RDONE, S_ERR2: w_state_next = w_phase_state;
            S_WR:    w_state_next = w_stall ? S_WR : w_phase_state;
            S_RD:    w_state_next = w_stall ? S_RD : S_RWAIT;
            S_RWAIT: begin
                if (bus.rsp_valid) w_state_next = bus.rsp_err ? S_ERR1 : S_RDONE;
            end
            S_ERR1:  w_state_next = S_ERR2;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: AHB ready and error response
    always_comb begin
        w_hreadyout = 1'b1;
        w_hresp     = 1'b0;
        case (r_state)
            S_WR:    w_hreadyout = !w_stall;
            S_RD:    w_hreadyout = 1'b0;
            S_RWAIT: w_hreadyout = 1'b0;
            S_ERR1: begin
                w_hreadyout = 1'b0;
                w_hresp     = 1'b1;
            end
            S_ERR2:  w_hresp = 1'b1;
            default: w_hreadyout = 1'b1;
        endcase
    end

    // Address-phase capture, beat counter and read data register
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_addr   <= '0;
            r_last   <= 1'b0;
            r_beat   <= '0;
            r_hrdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= bus.Haddr;
                r_last <= w_last;
                r_beat <= w_beat_idx;
            end
            if ((r_state == S_RWAIT) && bus.rsp_valid && !bus.rsp_err) begin
                r_hrdata <= bus.rsp_rdata;
            end
        end
    end

    // Request FIFO storage, pointers and occupancy
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_fifo_write[i] <= 1'b0;
                r_fifo_addr[i]  <= '0;
                r_fifo_wdata[i] <= '0;
                r_fifo_last[i]  <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_fifo_write[r_wr_ptr] <= (r_state == S_WR);
                r_fifo_addr[r_wr_ptr]  <= r_addr;
                r_fifo_wdata[r_wr_ptr] <= w_push_wdata;
                r_fifo_last[r_wr_ptr]  <= r_last;
                r_wr_ptr               <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.Hreadyout = w_hreadyout;
    assign bus.Hresp     = w_hresp;
    assign bus.Hrdata    = r_hrdata;
    assign bus.req_valid = !w_empty;
    assign bus.req_write = r_fifo_write[r_rd_ptr];
    assign bus.req_addr  = r_fifo_addr[r_rd_ptr];
    assign bus.req_wdata = r_fifo_wdata[r_rd_ptr];
    assign bus.req_last  = r_fifo_last[r_rd_ptr];
endmodule

// File: tb/tb_ahb_burst_slave.sv
// Directed bench for ahb_burst_slave. Inputs change on the falling edge and
// outputs are sampled 1 time unit later. Hready is looped back from Hreadyout.
module tb_ahb_burst_slave;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_WRAP4  = 3'd2;
    localparam logic [2:0] B_INCR4  = 3'd3;

    logic Hclk    = 1'b0;
    logic Hresetn = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] exp_incr_addr [5] = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h80};
    logic        exp_incr_last [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp_wrap_addr [4] = '{32'h38, 32'h3C, 32'h30, 32'h34};
    logic        exp_wrap_last [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    ahb_burst_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();
    assign bus_if.Hready = bus_if.Hreadyout;

    ahb_burst_slave #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .Hclk   (Hclk),
        .Hresetn(Hresetn),
        .bus    (bus_if)
    );

    always #5 Hclk = ~Hclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic last);
        chk({tag, "_valid"}, 64'(bus_if.req_valid), 64'(1'b1));
        chk({tag, "_write"}, 64'(bus_if.req_write), 64'(wr));
        chk({tag, "_addr"},  64'(bus_if.req_addr),  64'(addr));
        chk({tag, "_wdata"}, 64'(bus_if.req_wdata), 64'(wdata));
        chk({tag, "_last"},  64'(bus_if.req_last),  64'(last));
    endtask

    task automatic ap(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [2:0] burst);
        bus_if.Hsel   = (trans != T_IDLE);
        bus_if.Htrans = trans;
        bus_if.Hwrite = wr;
        bus_if.Haddr  = addr;
        bus_if.Hsize  = size;
        bus_if.Hburst = burst;
    endtask

    task automatic idle();
        ap(T_IDLE, 1'b0, 32'h0, 3'd2, B_SINGLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        bus_if.Hwdata    = '0;
        bus_if.req_ready = 1'b0;
        bus_if.rsp_valid = 1'b0;
        bus_if.rsp_rdata = '0;
        bus_if.rsp_err   = 1'b0;

        // Reset state
        repeat (2) @(negedge Hclk);
        #1;
        chk("rst_hreadyout", 64'(bus_if.Hreadyout), 64'd1);
        chk("rst_hresp",     64'(bus_if.Hresp),     64'd0);
        chk("rst_hrdata",    64'(bus_if.Hrdata),    64'd0);
        chk("rst_req_valid", 64'(bus_if.req_valid), 64'd0);
        chk("rst_req_write", 64'(bus_if.req_write), 64'd0);
        chk("rst_req_addr",  64'(bus_if.req_addr),  64'd0);
        chk("rst_req_wdata", 64'(bus_if.req_wdata), 64'd0);
        chk("rst_req_last",  64'(bus_if.req_last),  64'd0);
        @(negedge Hclk);
        Hresetn = 1'b1;

        // Single posted write
        bus_if.req_ready = 1'b1;
        @(negedge Hclk);
        ap(T_NONSEQ, 1'b1, 32'h100, 3'd2, B_SINGLE);
        #1 chk("w1_rdy_addr", 64'(bus_if.Hreadyout), 64'd1);
        @(negedge Hclk);
        idle();
        bus_if.Hwdata = 32'hDEADBEEF;
        #1 chk("w1_rdy_data", 64'(bus_if.Hreadyout), 64'd1);
        chk("w1_not_yet", 64'(bus_if.req_valid), 64'd0);
        @(negedge Hclk);
        #1 chk_head("w1", 1'b1, 32'h100, 32'hDEADBEEF, 1'b1);
        chk("w1_rdy_after", 64'(bus_if.Hreadyout), 64'd1);
        @(negedge Hclk);
        #1 chk("w1_one_push", 64'(bus_if.req_valid), 64'd0);

        // INCR4 fills the FIFO, a fifth write stalls until req_ready
        bus_if.req_ready = 1'b0;
        @(negedge Hclk);
        ap(T_NONSEQ, 1'b1, 32'h40, 3'd2, B_INCR4);
        for (int i = 1; i < 4; i++) begin
            @(negedge Hclk);
            bus_if.Hwdata = 32'hA0000000 + 32'(i - 1);
            ap(T_SEQ, 1'b1, 32'h40 + 32'(4 * i), 3'd2, B_INCR4);
            #1 chk("incr_rdy", 64'(bus_if.Hreadyout), 64'd1);
        end
        @(negedge Hclk);
        bus_if.Hwdata = 32'hA0000003;
        ap(T_NONSEQ, 1'b1, 32'h80, 3'd2, B_SINGLE);
        #1 chk("incr_rdy_last", 64'(bus_if.Hreadyout), 64'd1);
        @(negedge Hclk);
        bus_if.Hwdata = 32'hA0000004;
        idle();
        #1 chk("full_stall", 64'(bus_if.Hreadyout), 64'd0);
        repeat (2) begin
            @(negedge Hclk);
            #1 chk("full_hold", 64'(bus_if.Hreadyout), 64'd0);
        end
        @(negedge Hclk);
        bus_if.req_ready = 1'b1;
        #1 chk("full_release", 64'(bus_if.Hreadyout), 64'd1);
        chk_head("incr0", 1'b1, exp_incr_addr[0], 32'hA0000000, exp_incr_last[0]);
        for (int i = 1; i < 5; i++) begin
            @(negedge Hclk);
            #1 chk_head("incr", 1'b1, exp_incr_addr[i], 32'hA0000000 + 32'(i), exp_incr_last[i]);
        end
        @(negedge Hclk);
        #1 chk("incr_drained", 64'(bus_if.req_valid), 64'd0);

        // Read with a delayed response
        @(negedge Hclk);
        ap(T_NONSEQ, 1'b0, 32'h20, 3'd2, B_SINGLE);
        @(negedge Hclk);
        idle();
        #1 chk("rd_wait0", 64'(bus_if.Hreadyout), 64'd0);
        chk("rd_not_yet", 64'(bus_if.req_valid), 64'd0);
        @(negedge Hclk);
        #1 chk_head("rd", 1'b0, 32'h20, 32'h0, 1'b1);
        chk("rd_wait1", 64'(bus_if.Hreadyout), 64'd0);
        repeat (4) begin
            @(negedge Hclk);
            #1 chk("rd_wait", 64'(bus_if.Hreadyout), 64'd0);
        end
        @(negedge Hclk);
        bus_if.rsp_valid = 1'b1;
        bus_if.rsp_rdata = 32'h12345678;
        #1 chk("rd_rsp_cycle", 64'(bus_if.Hreadyout), 64'd0);
        @(negedge Hclk);
        bus_if.rsp_valid = 1'b0;
        bus_if.rsp_rdata = '0;
        #1 chk("rd_done_rdy", 64'(bus_if.Hreadyout), 64'd1);
        chk("rd_done_data", 64'(bus_if.Hrdata), 64'h12345678);
        chk("rd_done_resp", 64'(bus_if.Hresp), 64'd0);
        @(negedge Hclk);
        #1 chk("rd_hold_data", 64'(bus_if.Hrdata), 64'h12345678);

        // Read answered with an error
        @(negedge Hclk);
        ap(T_NONSEQ, 1'b0, 32'h24, 3'd2, B_SINGLE);
        @(negedge Hclk);
        idle();
        @(negedge Hclk);
        bus_if.rsp_valid = 1'b1;
        bus_if.rsp_err   = 1'b1;
        bus_if.rsp_rdata = 32'hFFFF0000;
        #1 chk("rerr_wait", 64'(bus_if.Hreadyout), 64'd0);
        @(negedge Hclk);
        bus_if.rsp_valid = 1'b0;
        bus_if.rsp_err   = 1'b0;
        #1 chk("rerr1_resp", 64'(bus_if.Hresp), 64'd1);
        chk("rerr1_rdy", 64'(bus_if.Hreadyout), 64'd0);
        @(negedge Hclk);
        #1 chk("rerr2_resp", 64'(bus_if.Hresp), 64'd1);
        chk("rerr2_rdy", 64'(bus_if.Hreadyout), 64'd1);
        chk("rerr_hrdata", 64'(bus_if.Hrdata), 64'h12345678);
        @(negedge Hclk);
        #1 chk("rerr_after", 64'(bus_if.Hresp), 64'd0);

        // Misaligned word write
        @(negedge Hclk);
        ap(T_NONSEQ, 1'b1, 32'h102, 3'd2, B_SINGLE);
        @(negedge Hclk);
        idle();
        bus_if.Hwdata = 32'h55;
        #1 chk("mis1_resp", 64'(bus_if.Hresp), 64'd1);
        chk("mis1_rdy", 64'(bus_if.Hreadyout), 64'd0);
        chk("mis1_nopush", 64'(bus_if.req_valid), 64'd0);
        @(negedge Hclk);
        #1 chk("mis2_resp", 64'(bus_if.Hresp), 64'd1);
        chk("mis2_rdy", 64'(bus_if.Hreadyout), 64'd1);
        @(negedge Hclk);
        #1 chk("mis_after", 64'(bus_if.Hresp), 64'd0);
        chk("mis_nopush", 64'(bus_if.req_valid), 64'd0);

        // Oversize read (doubleword on a 32-bit bus)
        @(negedge Hclk);
        ap(T_NONSEQ, 1'b0, 32'h0, 3'd3, B_SINGLE);
        @(negedge Hclk);
        idle();
        #1 chk("big1_resp", 64'(bus_if.Hresp), 64'd1);
        chk("big1_rdy", 64'(bus_if.Hreadyout), 64'd0);
        @(negedge Hclk);
        #1 chk("big2_resp", 64'(bus_if.Hresp), 64'd1);
        @(negedge Hclk);
        #1 chk("big_nopush", 64'(bus_if.req_valid), 64'd0);

        // WRAP4 from 0x38 with a BUSY inside the burst
        bus_if.req_ready = 1'b0;
        @(negedge Hclk);
        ap(T_NONSEQ, 1'b1, 32'h38, 3'd2, B_WRAP4);
        @(negedge Hclk);
        bus_if.Hwdata = 32'hB0000000;
        ap(T_SEQ, 1'b1, 32'h3C, 3'd2, B_WRAP4);
        @(negedge Hclk);
        bus_if.Hwdata = 32'hB0000001;
        ap(T_BUSY, 1'b1, 32'h30, 3'd2, B_WRAP4);
        #1 chk("busy_rdy", 64'(bus_if.Hreadyout), 64'd1);
        chk("busy_resp", 64'(bus_if.Hresp), 64'd0);
        @(negedge Hclk);
        ap(T_SEQ, 1'b1, 32'h30, 3'd2, B_WRAP4);
        @(negedge Hclk);
        bus_if.Hwdata = 32'hB0000002;
        ap(T_SEQ, 1'b1, 32'h34, 3'd2, B_WRAP4);
        @(negedge Hclk);
        bus_if.Hwdata = 32'hB0000003;
        idle();
        #1 chk("wrap_rdy", 64'(bus_if.Hreadyout), 64'd1);
        @(negedge Hclk);
        bus_if.req_ready = 1'b1;
        #1 chk_head("wrap0", 1'b1, exp_wrap_addr[0], 32'hB0000000, exp_wrap_last[0]);
        for (int i = 1; i < 4; i++) begin
            @(negedge Hclk);
            #1 chk_head("wrap", 1'b1, exp_wrap_addr[i], 32'hB0000000 + 32'(i), exp_wrap_last[i]);
        end
        @(negedge Hclk);
        #1 chk("wrap_drained", 64'(bus_if.req_valid), 64'd0);

        // WRAP4 with an out-of-sequence SEQ beat at 0x40
        bus_if.req_ready = 1'b0;
        @(negedge Hclk);
        ap(T_NONSEQ, 1'b1, 32'h38, 3'd2, B_WRAP4);
        @(negedge Hclk);
        bus_if.Hwdata = 32'hC0000000;
        ap(T_SEQ, 1'b1, 32'h40, 3'd2, B_WRAP4);
        @(negedge Hclk);
        bus_if.Hwdata = 32'hC0000001;
        idle();
`ifdef AHB_BURST_SLAVE_ADDR_CHECK_EN
        #1 chk("bad_seq1_resp", 64'(bus_if.Hresp), 64'd1);
        chk("bad_seq1_rdy", 64'(bus_if.Hreadyout), 64'd0);
        @(negedge Hclk);
        #1 chk("bad_seq2_resp", 64'(bus_if.Hresp), 64'd1);
        chk("bad_seq2_rdy", 64'(bus_if.Hreadyout), 64'd1);
        @(negedge Hclk);
        bus_if.req_ready = 1'b1;
        #1 chk_head("bad_seq_head", 1'b1, 32'h38, 32'hC0000000, 1'b0);
        @(negedge Hclk);
        #1 chk("bad_seq_nopush", 64'(bus_if.req_valid), 64'd0);
`else
        #1 chk("seq40_resp", 64'(bus_if.Hresp), 64'd0);
        chk("seq40_rdy", 64'(bus_if.Hreadyout), 64'd1);
        @(negedge Hclk);
        #1 chk("seq40_resp2", 64'(bus_if.Hresp), 64'd0);
        @(negedge Hclk);
        bus_if.req_ready = 1'b1;
        #1 chk_head("seq40_h0", 1'b1, 32'h38, 32'hC0000000, 1'b0);
        @(negedge Hclk);
        #1 chk_head("seq40_h1", 1'b1, 32'h40, 32'hC0000001, 1'b0);
        @(negedge Hclk);
        #1 chk("seq40_drained", 64'(bus_if.req_valid), 64'd0);
`endif

        // Reset while waiting for a read response with two entries queued
        bus_if.req_ready = 1'b0;
        @(negedge Hclk);
        ap(T_NONSEQ, 1'b1, 32'h200, 3'd2, B_SINGLE);
        @(negedge Hclk);
        bus_if.Hwdata = 32'hA5A5A5A5;
        ap(T_NONSEQ, 1'b0, 32'h204, 3'd2, B_SINGLE);
        @(negedge Hclk);
        idle();
        #1 chk("rst_rd_rdy0", 64'(bus_if.Hreadyout), 64'd0);
        @(negedge Hclk);
        #1 chk("rst_rwait_rdy", 64'(bus_if.Hreadyout), 64'd0);
        chk_head("rst_q", 1'b1, 32'h200, 32'hA5A5A5A5, 1'b1);
        Hresetn = 1'b0;
        #1 chk("rst_mid_valid", 64'(bus_if.req_valid), 64'd0);
        chk("rst_mid_rdy", 64'(bus_if.Hreadyout), 64'd1);
        chk("rst_mid_resp", 64'(bus_if.Hresp), 64'd0);
        chk("rst_mid_addr", 64'(bus_if.req_addr), 64'd0);
        chk("rst_mid_hrdata", 64'(bus_if.Hrdata), 64'd0);
        @(negedge Hclk);
        Hresetn = 1'b1;
        bus_if.rsp_valid = 1'b1;
        bus_if.rsp_rdata = 32'h00000BAD;
        #1 chk("post_rst_rdy", 64'(bus_if.Hreadyout), 64'd1);
        @(negedge Hclk);
        bus_if.rsp_valid = 1'b0;
        #1 chk("post_rst_rdy2", 64'(bus_if.Hreadyout), 64'd1);
        chk("post_rst_hrdata", 64'(bus_if.Hrdata), 64'd0);
        chk("post_rst_valid", 64'(bus_if.req_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
